// File: rtl/activation_cache_writer.sv
// rtl/activation_cache_writer.sv - write-side way selection and strobe generation for the 5-way activation cache
module activation_cache_writer #(
    parameter int NWAYS     = 5,
    parameter int WORD_SIZE = 16,
    parameter int TAG_SIZE  = 8,
    localparam int WAY_W    = $clog2(NWAYS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [TAG_SIZE-1:0]  req_tag,
    input  logic [WORD_SIZE-1:0] req_data,
    input  logic                 flush,
    output logic                 we_0,
    output logic                 we_1,
    output logic                 we_2,
    output logic                 we_3,
    output logic                 we_4,
    output logic [WORD_SIZE-1:0] wr_data,
    output logic [TAG_SIZE-1:0]  wr_tag,
    output logic [WAY_W-1:0]     wr_way,
    output logic                 done,
    output logic                 done_hit,
    output logic [NWAYS-1:0]     way_valid,
    output logic [TAG_SIZE-1:0]  tag_0,
    output logic [TAG_SIZE-1:0]  tag_1,
    output logic [TAG_SIZE-1:0]  tag_2,
    output logic [TAG_SIZE-1:0]  tag_3,
    output logic [TAG_SIZE-1:0]  tag_4
);

    typedef enum logic [1:0] {IDLE, LOOKUP, WRITE} state_t;

    state_t               state;
    logic [WAY_W-1:0]     rr_ptr;
    logic [TAG_SIZE-1:0]  tags [NWAYS];
    logic [TAG_SIZE-1:0]  lat_tag;
    logic [WORD_SIZE-1:0] lat_data;
    logic [NWAYS-1:0]     we_r;
    logic                 repl;

    logic                 hit_found;
    logic                 free_found;
    logic [WAY_W-1:0]     hit_idx;
    logic [WAY_W-1:0]     free_idx;
    logic [WAY_W-1:0]     sel_idx;
    logic                 sel_repl;

    assign req_ready = (state == IDLE) && !flush;

    assign we_0  = we_r[0];
    assign we_1  = we_r[1];
    assign we_2  = we_r[2];
    assign we_3  = we_r[3];
    assign we_4  = we_r[4];
    assign tag_0 = tags[0];
    assign tag_1 = tags[1];
    assign tag_2 = tags[2];
    assign tag_3 = tags[3];
    assign tag_4 = tags[4];

    // Scanning from the top down lets the lowest matching or free index win.
    always_comb begin
        hit_found  = 1'b0;
        free_found = 1'b0;
        hit_idx    = '0;
        free_idx   = '0;
        for (int i = NWAYS - 1; i >= 0; i--) begin
            if (way_valid[i] && (tags[i] == lat_tag)) begin
                hit_found = 1'b1;
                hit_idx   = WAY_W'(i);
            end
            if (!way_valid[i]) begin
                free_found = 1'b1;
                free_idx   = WAY_W'(i);
            end
        end
        sel_repl = !hit_found && !free_found;
        if (hit_found)
            sel_idx = hit_idx;
        else if (free_found)
            sel_idx = free_idx;
        else
            sel_idx = rr_ptr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            way_valid <= '0;
            for (int i = 0; i < NWAYS; i++)
                tags[i] <= '0;
            lat_tag   <= '0;
            lat_data  <= '0;
            we_r      <= '0;
            repl      <= 1'b0;
            wr_data   <= '0;
            wr_tag    <= '0;
            wr_way    <= '0;
            done      <= 1'b0;
            done_hit  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        way_valid <= '0;
                    end else if (req_valid) begin
                        lat_tag  <= req_tag;
                        lat_data <= req_data;
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    wr_way   <= sel_idx;
                    wr_tag   <= lat_tag;
                    wr_data  <= lat_data;
                    done_hit <= hit_found;
                    repl     <= sel_repl;
                    we_r     <= NWAYS'(1) << sel_idx;
                    done     <= 1'b1;
                    state    <= WRITE;
                end
                WRITE: begin
                    we_r              <= '0;
                    done              <= 1'b0;
                    way_valid[wr_way] <= 1'b1;
                    tags[wr_way]      <= lat_tag;
                    // Victim pointer only advances when a valid way was evicted.
                    if (repl)
                        rr_ptr <= (rr_ptr == WAY_W'(NWAYS - 1)) ? '0 : rr_ptr + WAY_W'(1);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_activation_cache_writer.sv
// tb/tb_activation_cache_writer.sv - self-checking bench for activation_cache_writer
module tb_activation_cache_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  req_tag = '0;
    logic [15:0] req_data = '0;
    logic        req_ready;
    logic        we_0, we_1, we_2, we_3, we_4;
    logic [15:0] wr_data;
    logic [7:0]  wr_tag;
    logic [2:0]  wr_way;
    logic        done, done_hit;
    logic [4:0]  way_valid;
    logic [7:0]  tag_0, tag_1, tag_2, tag_3, tag_4;
    logic [4:0]  we_vec;
    logic [7:0]  dut_tag [5];

    assign we_vec = {we_4, we_3, we_2, we_1, we_0};
    assign dut_tag[0] = tag_0;
    assign dut_tag[1] = tag_1;
    assign dut_tag[2] = tag_2;
    assign dut_tag[3] = tag_3;
    assign dut_tag[4] = tag_4;

    activation_cache_writer dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_tag(req_tag), .req_data(req_data), .flush(flush),
        .we_0(we_0), .we_1(we_1), .we_2(we_2), .we_3(we_3), .we_4(we_4),
        .wr_data(wr_data), .wr_tag(wr_tag), .wr_way(wr_way),
        .done(done), .done_hit(done_hit), .way_valid(way_valid),
        .tag_0(tag_0), .tag_1(tag_1), .tag_2(tag_2), .tag_3(tag_3), .tag_4(tag_4)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: cache contents, pending write and its commit age in cycles since acceptance.
    bit          m_valid [5];
    logic [7:0]  m_tag [5];
    int          m_rr;
    bit          pend;
    int          age;
    int          p_way;
    bit          p_hit, p_repl;
    logic [7:0]  p_tag;
    logic [15:0] p_data;
    int          l_way;
    logic [7:0]  l_tag;
    logic [15:0] l_data;

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
        end
        m_rr = 0; pend = 1'b0; age = 0;
        l_way = 0; l_tag = '0; l_data = '0;
    endtask

    task automatic pick(input logic [7:0] tag, output int way, output bit hit, output bit repl);
        way = -1; hit = 1'b0; repl = 1'b0;
        for (int i = 0; i < 5; i++)
            if (way < 0 && m_valid[i] && m_tag[i] == tag) begin
                way = i; hit = 1'b1;
            end
        for (int i = 0; i < 5; i++)
            if (way < 0 && !m_valid[i])
                way = i;
        if (way < 0) begin
            way = m_rr; repl = 1'b1;
        end
    endtask

    task automatic compare();
        logic [4:0] ev;
        logic [4:0] mv;
        bit         in_write;
        in_write = pend && age == 2;
        ev = in_write ? 5'(1 << p_way) : 5'b0;
        for (int i = 0; i < 5; i++)
            mv[i] = m_valid[i];
        check("we", we_vec, ev);
        check("done", done, in_write);
        if (in_write)
            check("done_hit", done_hit, p_hit);
        check("wr_way", wr_way, l_way);
        check("wr_tag", wr_tag, l_tag);
        check("wr_data", wr_data, l_data);
        check("req_ready", req_ready, !pend && !flush);
        check("way_valid", way_valid, mv);
        for (int i = 0; i < 5; i++)
            check($sformatf("tag_%0d", i), dut_tag[i], m_tag[i]);
    endtask

    // Applies the effect of the coming rising edge using the inputs held across it.
    task automatic advance();
        if (pend) begin
            if (age == 1) begin
                age = 2;
                l_way = p_way; l_tag = p_tag; l_data = p_data;
            end else begin
                m_valid[p_way] = 1'b1;
                m_tag[p_way]   = p_tag;
                if (p_repl)
                    m_rr = (m_rr + 1) % 5;
                pend = 1'b0;
            end
        end else if (flush) begin
            for (int i = 0; i < 5; i++)
                m_valid[i] = 1'b0;
        end else if (req_valid) begin
            pick(req_tag, p_way, p_hit, p_repl);
            p_tag = req_tag; p_data = req_data;
            pend = 1'b1; age = 1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n)
                model_reset();
            compare();
            if (rst_n)
                advance();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] tag, input logic [15:0] data,
                            input int exp_way, input bit exp_hit, input bit flush_mid);
        int lat;
        lat = 0;
        req_tag = tag; req_data = data; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        req_tag = 8'($urandom);
        req_data = 16'($urandom);
        if (flush_mid)
            flush = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            step();
            flush = 1'b0;
        end
        check("latency", lat, 2);
        check("lit_wr_way", wr_way, exp_way);
        check("lit_done_hit", done_hit, exp_hit);
        check("lit_wr_tag", wr_tag, tag);
        check("lit_wr_data", wr_data, data);
        step();
    endtask

    initial begin
        int acc;
        repeat (3) step();
        check("rst_way_valid", way_valid, 5'b0);
        check("rst_done", done, 1'b0);
        check("rst_wr_data", wr_data, 16'h0);
        check("rst_done_hit", done_hit, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", req_ready, 1'b1);
        step();

        do_write(8'h10, 16'h1000, 0, 1'b0, 1'b0);
        do_write(8'h11, 16'h1100, 1, 1'b0, 1'b0);
        do_write(8'h12, 16'h1200, 2, 1'b0, 1'b0);
        @(negedge clk);
        check("lit_fill3", way_valid, 5'b00111);
        step();

        do_write(8'h11, 16'hBEEF, 1, 1'b1, 1'b0);
        do_write(8'h13, 16'h1300, 3, 1'b0, 1'b0);
        do_write(8'h14, 16'h1400, 4, 1'b0, 1'b0);
        do_write(8'h20, 16'h2000, 0, 1'b0, 1'b0);
        do_write(8'h21, 16'h2100, 1, 1'b0, 1'b0);
        do_write(8'h22, 16'h2200, 2, 1'b0, 1'b0);
        do_write(8'h23, 16'h2300, 3, 1'b0, 1'b0);
        do_write(8'h24, 16'h2400, 4, 1'b0, 1'b0);
        do_write(8'h25, 16'h2500, 0, 1'b0, 1'b0);

        flush = 1'b1; req_valid = 1'b1; req_tag = 8'h77;
        @(negedge clk);
        check("lit_flush_ready", req_ready, 1'b0);
        step();
        @(negedge clk);
        check("lit_flush_valid", way_valid, 5'b0);
        step();
        flush = 1'b0; req_valid = 1'b0;
        do_write(8'h30, 16'h3000, 0, 1'b0, 1'b0);
        do_write(8'h22, 16'h3100, 1, 1'b0, 1'b0);
        do_write(8'h40, 16'h4000, 2, 1'b0, 1'b1);
        @(negedge clk);
        check("lit_flush_lookup", way_valid, 5'b00111);
        step();

        acc = 0;
        req_tag = 8'h50; req_data = 16'h5000; req_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (req_valid && req_ready)
                acc++;
            step();
            req_tag = 8'(8'h51 + k);
            req_data = 16'(16'h5001 + k);
        end
        req_valid = 1'b0;
        check("lit_accepts", acc, 4);
        repeat (4) step();

        req_tag = 8'h66; req_data = 16'h6600; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        check("lit_mid_done", done, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("lit_rst_we", we_vec, 5'b0);
        check("lit_rst_done", done, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("lit_post_valid", way_valid, 5'b0);
        check("lit_post_ready", req_ready, 1'b1);
        step();
        do_write(8'h60, 16'h6000, 0, 1'b0, 1'b0);
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/activation_cache_writer.md
# activation_cache_writer

Write-side controller for the 5-way activation cache. It accepts activation write requests over a valid/ready handshake and keeps one tag and valid bit per way. For each request it picks the target way (tag hit, else first free way, else round-robin victim) and drives a one-cycle one-hot write strobe plus shared data/tag buses into the way storage. Its `way_valid` and tag outputs are what the read-side lookup uses to produce the way index for activation output selection.

## Interface
- `NWAYS`, 5, number of ways; fixed at 5, since there is one strobe port per way.
- `WORD_SIZE`, 16, activation width in bits.
- `TAG_SIZE`, 8, tag width in bits.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  write request present.
- `req_ready`  out  1  controller can accept a request this cycle.
- `req_tag`  in  TAG_SIZE  tag of the activation being written.
- `req_data`  in  WORD_SIZE  activation value.
- `flush`  in  1  invalidate all ways; sampled in IDLE only.
- `we_0`..`we_4`  out  1 each  per-way write strobe; at most one is high.
- `wr_data`  out  WORD_SIZE  data bus shared by all ways.
- `wr_tag`  out  TAG_SIZE  tag bus shared by all ways.
- `wr_way`  out  $clog2(NWAYS)  index of the way being written.
- `done`  out  1  one-cycle pulse when the write is committed.
- `done_hit`  out  1  qualified by `done`: 1 means the tag already existed (update), 0 means allocation.
- `way_valid`  out  NWAYS  valid bit of each way.
- `tag_0`..`tag_4`  out  TAG_SIZE each  stored tag per way.

## Operation
- FSM states: IDLE, LOOKUP, WRITE.
- **IDLE**
  - `req_ready` = `!flush`.
  - If `flush` is high: clear all valid bits this cycle. Tags are kept. No request is accepted.
  - Else, if `req_valid` is high: latch `req_tag` and `req_data`, then go to LOOKUP.
- **LOOKUP** (`req_ready` = 0)
  - Compare the latched tag against every way whose valid bit is set.
  - Target selection, in priority order:
    1. Matching way. A duplicate match is impossible by construction; if it occurs anyway, the lowest index wins.
    2. Lowest-index invalid way.
    3. The way pointed to by `rr_ptr`.
  - Register the target index and the hit flag, then go to WRITE.
- **WRITE** (`req_ready` = 0)
  - Assert `we_<target>` and `done`. Drive `wr_way`, `wr_tag` and `wr_data` from the latched values. `done_hit` carries the hit flag.
  - Set `way_valid[target]` and load `tag_<target>` with the latched tag.
  - Update `rr_ptr` only on case 3 (replacement of a valid way): increment, wrapping 4→0. It does not move on a hit or on a fill of an invalid way.
  - Go to IDLE.
- Outside WRITE: all `we_*` = 0 and `done` = 0. `wr_data`, `wr_tag` and `wr_way` hold their last values; consumers qualify them with the strobes.
- `flush` asserted in LOOKUP or WRITE is ignored. The in-flight write completes normally.
- Reset, asynchronous and effective at any point including mid-operation:
  - state = IDLE, `rr_ptr` = 0, `way_valid` = 0, all tags = 0.
  - `wr_data` = 0, `wr_tag` = 0, `wr_way` = 0.
  - `we_*` = 0, `done` = 0, `done_hit` = 0.
  - `req_ready` = 1 once reset is released, provided `flush` is low.
  - Any in-flight write is dropped and no strobe is issued.

## Timing
- Request accepted on edge E (`req_valid` & `req_ready` high).
- The LOOKUP cycle follows E. The strobe, `done`, `wr_*` and `done_hit` are high in the next cycle (WRITE).
- `way_valid` and the tags show the new contents after the edge that ends WRITE.
- `req_ready` returns high in the cycle after WRITE.
- Throughput: one request per 3 cycles.
- Back-to-back requests to the same tag: the second request's LOOKUP sees the updated tag, so it is a hit.
- `req_data` and `req_tag` may change after acceptance with no effect on the write in progress.

## Test plan
- **Reset, then writes to empty ways:** reset, then write tags 0x10, 0x11, 0x12 → `we_0`, `we_1`, `we_2` strobes in turn, each with `done_hit` = 0; `way_valid` = 5'b00111; each `done` occurs 2 cycles after acceptance.
- **Hit update:** with tag 0x11 held in way 1, write tag 0x11 with data 0xBEEF → `we_1` strobe, `wr_data` = 0xBEEF, `done_hit` = 1; `rr_ptr` unchanged.
- **Round-robin replacement:** fill all 5 ways, then write new tags 0x20, 0x21, 0x22 → targets are ways 0, 1, 2; `rr_ptr` ends at 3. With `rr_ptr` = 4, a new tag targets way 4 and `rr_ptr` wraps to 0.
- **Flush:**
  - `flush` high in IDLE with all ways valid → `way_valid` = 0 next cycle; `req_ready` = 0 while `flush` is high; the next write goes to way 0.
  - `flush` pulsed during LOOKUP → ignored; the write completes; `way_valid` is unchanged apart from the written way.
- **Handshake:** hold `req_valid` high continuously with changing data → exactly one acceptance per 3 cycles; no strobe for data presented while `req_ready` = 0.
- **Reset mid-operation:** assert `rst_n` low during WRITE → the strobe drops immediately; after release, `way_valid` = 0 and `req_ready` = 1.
